// File: rtl/sign_mag_serial_converter.sv
// Bit-serial converter between sign-magnitude and two's-complement.
// A single carry flop walks the invert-and-add-one across the magnitude bits,
// LSB first, one bit per cycle. The same recurrence serves both directions
// because the mapping is its own inverse. Only the unrepresentable code
// 100...0 differs, and it is resolved from the final carry.
module sign_mag_serial_converter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             except,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-2:0] mag_q;
    logic             sign_q;
    logic             mode_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic             except_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    // One serial step: conditional invert, add the carry, and shift the result in at the top
    logic             flip_bit;
    logic             res_bit;
    logic             carry_d;
    logic [WIDTH-2:0] mag_d;

    // Process mag_q[0] this cycle. The result enters at the MSB end, so after
    // WIDTH-1 steps every bit sits at its original position.
    always_comb begin
        flip_bit           = mag_q[0] ^ sign_q;
        res_bit            = flip_bit ^ carry_q;
        carry_d            = flip_bit & carry_q;
        mag_d              = mag_q >> 1;
        mag_d[WIDTH-2]     = res_bit;
    end

    // Control FSM with registered handshake outputs and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            sign_q      <= 1'b0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            dout_q      <= '0;
            except_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mag_q      <= din[WIDTH-2:0];
                        sign_q     <= din[WIDTH-1];
                        mode_q     <= mode;
                        // A negative operand is inverted and then incremented. Seeding the carry with the sign bit supplies the +1.
                        carry_q    <= din[WIDTH-1];
                        cnt_q      <= '0;
                        state_q    <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    mag_q   <= mag_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        if (carry_d) begin
                            // A carry that survives every bit means the input was 100...0.
                            // In mode 0 this is "-0" and maps to zero. In mode 1 it is the
                            // most-negative value, which saturates.
                            except_q <= 1'b1;
                            dout_q   <= mode_q ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
                        end else begin
                            except_q <= 1'b0;
                            dout_q   <= {sign_q, mag_d};
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign dout      = dout_q;
    assign except    = except_q;

endmodule

// File: tb/tb_sign_mag_serial_converter.sv
// Testbench for sign_mag_serial_converter. It runs a WIDTH=8 and a WIDTH=4
// instance. Expected results come from a value-level model: decode the input
// number, then re-encode it in the other format.
module tb_sign_mag_serial_converter;

    logic       clk = 1'b0;
    logic       reset;

    logic       in_valid8, in_ready8, mode8, out_valid8, out_ready8, except8, busy8;
    logic [7:0] din8, dout8;
    logic       in_valid4, in_ready4, mode4, out_valid4, out_ready4, except4, busy4;
    logic [3:0] din4, dout4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sign_mag_serial_converter #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .din(din8), .mode(mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .dout(dout8),
        .except(except8), .busy(busy8)
    );

    sign_mag_serial_converter #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid4), .in_ready(in_ready4), .din(din4), .mode(mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .dout(dout4),
        .except(except4), .busy(busy4)
    );

    typedef struct {
        logic [7:0] din;
        logic       mode;
        logic [7:0] dout;
        logic       exc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Value-level reference. Decode the input as a signed number in the source
    // format, then encode it in the destination format.
    function automatic void model(input int w, input int d, input int m,
                                  output int res, output int exc);
        int half, full, v;
        half = 1 << (w - 1);
        full = 1 << w;
        exc  = 0;
        if (m == 0) begin
            // Sign-magnitude to two's complement.
            v = (d >= half) ? -(d - half) : d;
            if (d == half) begin
                res = 0;
                exc = 1;
            end else begin
                res = (v + full) % full;
            end
        end else begin
            // Two's complement to sign-magnitude.
            v = (d >= half) ? d - full : d;
            if (v == -half) begin
                res = half;
                exc = 1;
            end else if (v < 0) begin
                res = half + (-v);
            end else begin
                res = v;
            end
        end
    endfunction

    // Run one request through the WIDTH=8 instance. Report the result and the
    // number of edges from accept to out_valid.
    task automatic run8(input logic [7:0] d, input logic m,
                        output int res, output int exc, output int lat);
        int guard = 0;
        while (!in_ready8 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_valid8 = 1'b1; din8 = d; mode8 = m;
        @(posedge clk); #1;
        in_valid8 = 1'b0; din8 = ~d; mode8 = ~m;
        lat = 1;
        while (!out_valid8 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        // The loop counts the accept edge itself, so subtract it back out.
        lat = lat - 1;
        res = int'(dout8);
        exc = int'(except8);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        $display("[TB] w8 din=0x%02h mode=%0d -> dout=0x%02h except=%0d lat=%0d", d, m, res, exc, lat);
    endtask

    task automatic run4(input logic [3:0] d, input logic m,
                        output int res, output int exc, output int lat);
        int guard = 0;
        while (!in_ready4 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_valid4 = 1'b1; din4 = d; mode4 = m;
        @(posedge clk); #1;
        in_valid4 = 1'b0; din4 = ~d;
        lat = 1;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        lat = lat - 1;
        res = int'(dout4);
        exc = int'(except4);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        $display("[TB] w4 din=0x%0h mode=%0d -> dout=0x%0h except=%0d lat=%0d", d, m, res, exc, lat);
    endtask

    initial begin
        int res, exc, lat, eres, eexc, guard;
        logic [7:0] rd;
        logic       rm;

        vecs[0] = '{din: 8'h85, mode: 1'b0, dout: 8'hFB, exc: 1'b0};
        vecs[1] = '{din: 8'hFB, mode: 1'b1, dout: 8'h85, exc: 1'b0};
        vecs[2] = '{din: 8'h37, mode: 1'b0, dout: 8'h37, exc: 1'b0};
        vecs[3] = '{din: 8'h37, mode: 1'b1, dout: 8'h37, exc: 1'b0};
        vecs[4] = '{din: 8'h80, mode: 1'b0, dout: 8'h00, exc: 1'b1};
        vecs[5] = '{din: 8'h80, mode: 1'b1, dout: 8'h80, exc: 1'b1};
        vecs[6] = '{din: 8'hFF, mode: 1'b1, dout: 8'h81, exc: 1'b0};

        reset = 1'b1;
        in_valid8 = 1'b0; din8 = '0; mode8 = 1'b0; out_ready8 = 1'b0;
        in_valid4 = 1'b0; din4 = '0; mode4 = 1'b0; out_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("reset in_ready",  int'(in_ready8),  1);
        chk("reset out_valid", int'(out_valid8), 0);
        chk("reset busy",      int'(busy8),      0);
        chk("reset dout",      int'(dout8),      0);
        chk("reset except",    int'(except8),    0);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run8(vecs[i].din, vecs[i].mode, res, exc, lat);
            chk($sformatf("vec%0d dout", i),   res, int'(vecs[i].dout));
            chk($sformatf("vec%0d except", i), exc, int'(vecs[i].exc));
            chk($sformatf("vec%0d latency", i), lat, 7);
        end

        // Randomised against the value-level model
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            run8(rd, rm, res, exc, lat);
            model(8, int'(rd), int'(rm), eres, eexc);
            chk($sformatf("rand%0d dout", i),   res, eres);
            chk($sformatf("rand%0d except", i), exc, eexc);
        end

        // Backpressure: DONE holds while a new request waits on in_valid
        run8(8'h85, 1'b0, res, exc, lat);
        in_valid8 = 1'b1; din8 = 8'h85; mode8 = 1'b0;
        @(posedge clk); #1;
        din8 = 8'h12;
        guard = 0;
        while (!out_valid8 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp%0d dout", k),      int'(dout8),      8'hFB);
            chk($sformatf("bp%0d in_ready", k),  int'(in_ready8),  0);
            chk($sformatf("bp%0d out_valid", k), int'(out_valid8), 1);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        chk("bp release in_ready",  int'(in_ready8),  1);
        chk("bp release out_valid", int'(out_valid8), 0);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        chk("bp accept busy", int'(busy8), 1);
        guard = 0;
        while (!out_valid8 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        chk("bp second dout", int'(dout8), 8'h12);
        $display("[TB] w8 backpressure second request dout=0x%02h", dout8);
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        out_ready8 = 1'b0;

        // Reset on the third SHIFT cycle discards the operation
        in_valid8 = 1'b1; din8 = 8'h85; mode8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_shift in_ready",  int'(in_ready8),  1);
        chk("rst_shift out_valid", int'(out_valid8), 0);
        chk("rst_shift dout",      int'(dout8),      0);
        chk("rst_shift busy",      int'(busy8),      0);
        $display("[TB] w8 reset during SHIFT, dout=0x%02h out_valid=%0d", dout8, out_valid8);
        guard = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid8) guard++;
        end
        chk("rst_shift no stray result", guard, 0);
        run8(8'h85, 1'b0, res, exc, lat);
        chk("post-reset dout",   res, 8'hFB);
        chk("post-reset except", exc, 0);

        // WIDTH=4 exhaustive sweep
        for (int m = 0; m < 2; m++) begin
            for (int d = 0; d < 16; d++) begin
                run4(4'(d), 1'(m), res, exc, lat);
                model(4, d, m, eres, eexc);
                chk($sformatf("w4 m%0d d%0h dout", m, d),    res, eres);
                chk($sformatf("w4 m%0d d%0h except", m, d),  exc, eexc);
                chk($sformatf("w4 m%0d d%0h latency", m, d), lat, 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sign_mag_serial_converter.md
# sign_mag_serial_converter

Parametrised, bit-serial converter between sign-magnitude and two's-complement with a valid/ready handshake on both sides. It is the next generation of the combinational 8-bit negative-number inverter used on the TurkeyCounter datapath. The block serialises the invert-and-add-one across cycles with a single carry flop, supports both conversion directions, and flags the two unrepresentable corner codes. It sits between the up/down count register and the seven-segment display formatter, and may be instantiated at any width.

## Interface
- WIDTH, 8: data width in bits, including the sign bit at WIDTH-1; legal range 2..32.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  din/mode hold a request.
- in_ready  output  1  block can accept a request; high only in IDLE.
- din  input  WIDTH  operand.
- mode  input  1  0 = sign-magnitude to two's-complement; 1 = two's-complement to sign-magnitude.
- out_valid  output  1  dout/except hold a result; high only in DONE.
- out_ready  input  1  consumer takes the result.
- dout  output  WIDTH  converted value; registered.
- except  output  1  corner-case flag for the current result; registered.
- busy  output  1  high in SHIFT or DONE.

## Operation
- Request is accepted on a rising edge where in_valid && in_ready.
  - The edge captures din into a shift register, captures mode, and sets the carry to din[WIDTH-1].
  - It clears the bit counter and enters SHIFT.
- The sign bit s = din[WIDTH-1] passes through to dout[WIDTH-1] unchanged, except in the case listed below.
- Each SHIFT cycle processes bit i, starting at i = 0 and ending at i = WIDTH-2:
  - o = x[i] ^ s
  - result bit = o ^ c
  - c ← o & c
  - Bits are processed LSB first and the counter increments by 1.
- Positive inputs (s = 0) therefore pass through unchanged. Negative inputs (s = 1) produce {1, (~x[WIDTH-2:0] + 1) mod 2^(WIDTH-1)}.
- Corner codes are detected by the final carry. c = 1 after bit WIDTH-2 implies s = 1 and magnitude bits all 0, i.e. the input is exactly 100…0.
  - mode 0 (input is sign-magnitude "-0"): dout = 0 (sign cleared), except = 1.
  - mode 1 (input is two's-complement most-negative, which has no sign-magnitude image): dout = 100…0 (saturated), except = 1.
  - All other inputs: except = 0.
- States:
  - IDLE: in_ready = 1. Moves to SHIFT on accept.
  - SHIFT: moves to DONE on the edge that processes bit WIDTH-2.
  - DONE: out_valid = 1. Moves to IDLE on an edge with out_ready = 1; otherwise holds.
- Backpressure: while in DONE with out_ready = 0, dout and except hold stable and no new request is accepted.
- din and mode are don't-care outside the accept edge. Changes during SHIFT have no effect.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, busy = 0, dout = 0, except = 0, carry = 0, counter = 0.
- Reset has priority over every other event, including an accept or out_ready on the same edge.
  - Reset in SHIFT or DONE discards the operation; no partial result is ever presented.
- Latency: accept at edge 0 gives out_valid = 1 after edge WIDTH-1 (7 edges for WIDTH = 8).
- Throughput: with out_ready tied high, one result per WIDTH+1 cycles.
  - The DONE→IDLE edge and the next accept edge are distinct, so there is no same-edge turnaround.
- The counter is $clog2(WIDTH) bits wide and never wraps; it is cleared on accept.
- dout and except change only on the SHIFT→DONE edge or on reset.

## Test plan
- WIDTH = 8, mode 0, din = 0x85 (−5 in sign-magnitude) → dout = 0xFB, except = 0; out_valid rises exactly 7 edges after accept.
- WIDTH = 8, mode 1, din = 0xFB → dout = 0x85, except = 0; din = 0x37 in either mode → dout = 0x37.
- WIDTH = 8 corner codes:
  - mode 0, din = 0x80 → dout = 0x00, except = 1.
  - mode 1, din = 0x80 → dout = 0x80, except = 1.
  - mode 1, din = 0xFF → dout = 0x81, except = 0.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 with a new din → dout stable, in_ready = 0, nothing accepted; out_ready = 1 → IDLE, then the new request is accepted next edge.
- Reset asserted on the 3rd SHIFT cycle → next cycle IDLE, out_valid = 0, dout = 0; a following request 0x85 (mode 0) converts correctly to 0xFB.
- WIDTH = 4 instance: exhaustive sweep of all 16 codes in both modes against the reference formula; latency is 3 edges; except is set only for din = 0x8.
